// File: rtl/atmega_tim_pkg.sv
// atmega_tim_pkg: GTCCR layout and prescaler tap positions shared by the ATmega timer blocks
package atmega_tim_pkg;
  localparam int GTCCR_PSRSYNC = 0;
  localparam int GTCCR_PSRASY  = 1;
  localparam int GTCCR_TSM     = 7;
  localparam int TAP8    = 3;
  localparam int TAP64   = 6;
  localparam int TAP256  = 8;
  localparam int TAP1024 = 10;
  typedef struct packed {
    logic tsm;
    logic psrasy;
    logic psrsync;
  } gtccr_t;
  function automatic logic [7:0] gtccr_byte(input gtccr_t g);
    logic [7:0] b;
    b = 8'h00;
    b[GTCCR_TSM] = g.tsm;
    b[GTCCR_PSRASY] = g.psrasy;
    b[GTCCR_PSRSYNC] = g.psrsync;
    return b;
  endfunction
endpackage

// File: rtl/atmega_tim_t_sync.sv
// atmega_tim_t_sync: two-flop synchroniser plus history flop for the external T pin, with edge strobes
module atmega_tim_t_sync (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic mask,
  output logic rise,
  output logic fall
);
  logic meta, s1, s2;
  always_ff @(posedge clk)
    if (rst) {meta, s1, s2} <= 3'b000;
    else {meta, s1, s2} <= {t, meta, s1};
  assign rise = ~mask & s1 & ~s2;
  assign fall = ~mask & ~s1 & s2;
endmodule

// File: rtl/atmega_tim_prescaler.sv
// atmega_tim_prescaler: shared timer prescaler owning GTCCR; optional T-pin sync under ATMEGA_TIM_EXT_CLK_SYNC_EN
module atmega_tim_prescaler
  import atmega_tim_pkg::*;
#(
  parameter PLATFORM = "XILINX",
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_ADDR = 'h43
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic wr_i,
  input  logic rd_i,
  input  logic [7:0] bus_i,
  output logic [7:0] bus_o,
  output logic clk8_o,
  output logic clk64_o,
  output logic clk256_o,
  output logic clk1024_o,
  output logic psrasy_o,
  input  logic t_i,
  output logic t_rise_o,
  output logic t_fall_o
);
  localparam int unused_platform = $bits(PLATFORM);
  gtccr_t gtccr;
  logic [9:0] presc_cnt;
  logic sel;
  assign sel = addr_i == GTCCR_ADDR;
  // a write always wins over the self-clear that applies while TSM is 0
  always_ff @(posedge clk_i)
    if (rst_i) gtccr <= '0;
    else if (wr_i && sel) gtccr <= '{tsm: bus_i[GTCCR_TSM], psrasy: bus_i[GTCCR_PSRASY], psrsync: bus_i[GTCCR_PSRSYNC]};
    else if (!gtccr.tsm) gtccr <= '0;
  always_ff @(posedge clk_i)
    presc_cnt <= (rst_i || gtccr.psrsync) ? 10'h000 : presc_cnt + 10'd1;
  assign clk8_o    = presc_cnt[TAP8-1];
  assign clk64_o   = presc_cnt[TAP64-1];
  assign clk256_o  = presc_cnt[TAP256-1];
  assign clk1024_o = presc_cnt[TAP1024-1];
  assign psrasy_o  = gtccr.psrasy;
  assign bus_o     = (rd_i && sel) ? gtccr_byte(gtccr) : 8'h00;
`ifdef ATMEGA_TIM_EXT_CLK_SYNC_EN
  logic [4:0] unused_bits;
  assign unused_bits = bus_i[6:2];
  atmega_tim_t_sync u_t_sync (
    .clk(clk_i),
    .rst(rst_i),
    .t(t_i),
    .mask(gtccr.psrsync),
    .rise(t_rise_o),
    .fall(t_fall_o)
  );
`else
  logic [5:0] unused_bits;
  assign unused_bits = {bus_i[6:2], t_i};
  assign t_rise_o = 1'b0;
  assign t_fall_o = 1'b0;
`endif
endmodule

// File: tb/tb_atmega_tim_prescaler.sv
// tb_atmega_tim_prescaler: scoreboard bench; driver pushes expected outputs, monitor compares on falling edges
module tb_atmega_tim_prescaler;
  logic clk = 1'b0;
  logic rst_i = 1'b1, wr_i = 1'b0, rd_i = 1'b0, t_i = 1'b0;
  logic [7:0] addr_i = 8'h00, bus_i = 8'h00;
  logic [7:0] bus_o;
  logic clk8_o, clk64_o, clk256_o, clk1024_o, psrasy_o, t_rise_o, t_fall_o;
  always #5 clk = ~clk;
  atmega_tim_prescaler dut (
    .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .wr_i(wr_i), .rd_i(rd_i),
    .bus_i(bus_i), .bus_o(bus_o), .clk8_o(clk8_o), .clk64_o(clk64_o),
    .clk256_o(clk256_o), .clk1024_o(clk1024_o), .psrasy_o(psrasy_o),
    .t_i(t_i), .t_rise_o(t_rise_o), .t_fall_o(t_fall_o)
  );
  int cnt = 0;
  bit m_tsm = 0, m_asy = 0, m_sync = 0;
  bit th[$] = '{0, 0, 0};
  logic [14:0] sb[$];
  logic [14:0] exp_v, act_v;
  int cmp = 0, bad = 0;
  function automatic logic [14:0] expect_now();
    logic [7:0] b;
    logic r, f, c8, c64, c256, c1024;
    b = (rd_i && addr_i == 8'h43) ? {m_tsm, 5'b00000, m_asy, m_sync} : 8'h00;
    r = 1'b0;
    f = 1'b0;
`ifdef ATMEGA_TIM_EXT_CLK_SYNC_EN
    r = !m_sync && th[1] && !th[2];
    f = !m_sync && !th[1] && th[2];
`endif
    c8 = (cnt % 8) >= 4;
    c64 = (cnt % 64) >= 32;
    c256 = (cnt % 256) >= 128;
    c1024 = (cnt % 1024) >= 512;
    return {c8, c64, c256, c1024, m_asy, r, f, b};
  endfunction
  task automatic cyc(input bit r, input bit w, input bit rd, input logic [7:0] a, input logic [7:0] d, input bit t);
    @(posedge clk);
    #1;
    if (rst_i) begin
      cnt = 0; m_tsm = 0; m_asy = 0; m_sync = 0; th = '{0, 0, 0};
    end else begin
      cnt = m_sync ? 0 : (cnt + 1) % 1024;
      th.push_front(t_i);
      void'(th.pop_back());
      if (wr_i && addr_i == 8'h43) begin
        m_tsm = bus_i[7]; m_asy = bus_i[1]; m_sync = bus_i[0];
      end else if (!m_tsm) begin
        m_asy = 0; m_sync = 0;
      end
    end
    rst_i = r; wr_i = w; rd_i = rd; addr_i = a; bus_i = d; t_i = t;
    sb.push_back(expect_now());
  endtask
  always @(negedge clk)
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      act_v = {clk8_o, clk64_o, clk256_o, clk1024_o, psrasy_o, t_rise_o, t_fall_o, bus_o};
      cmp++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL outputs t=%0t got {clk8,64,256,1024,psrasy,rise,fall,bus}=%b_%b_%h required %b_%b_%h",
                 $time, act_v[14:11], act_v[10:8], act_v[7:0], exp_v[14:11], exp_v[10:8], exp_v[7:0]);
      end
    end
  initial begin
    bit tv;
    logic [7:0] d;
    repeat (3) cyc(1, 0, 0, 8'h00, 8'h00, 0);
    repeat (64) cyc(0, 0, 0, 8'h43, 8'h00, 0);
    repeat (2048) cyc(0, 0, 1'($urandom % 2), 8'h43, 8'h00, 0);
    cyc(0, 1, 0, 8'h43, 8'h01, 0);
    repeat (20) cyc(0, 0, 1, 8'h43, 8'h00, 0);
    cyc(0, 1, 0, 8'h43, 8'h81, 0);
    repeat (500) cyc(0, 0, 1'($urandom % 2), 8'h43, 8'h00, 0);
    cyc(0, 1, 1, 8'h43, 8'h00, 0);
    repeat (20) cyc(0, 0, 1, 8'h43, 8'h00, 0);
    cyc(0, 1, 0, 8'h43, 8'h82, 0);
    repeat (10) cyc(0, 0, 1, 8'h43, 8'h00, 0);
    cyc(0, 1, 0, 8'h43, 8'h02, 0);
    repeat (10) cyc(0, 0, 1, 8'h43, 8'h00, 0);
    repeat (3) cyc(0, 0, 1, 8'h39, 8'h00, 0);
    repeat (10) cyc(0, 0, 0, 8'h00, 8'h00, 1);
    repeat (10) cyc(0, 0, 0, 8'h00, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 8'h00, 1);
    repeat (10) cyc(0, 0, 0, 8'h00, 8'h00, 0);
    tv = 0;
    repeat (3000) begin
      d = 8'($urandom);
      if ($urandom % 4 != 0) d[7] = 1'b0;
      if ($urandom % 3 == 0) tv = ~tv;
      cyc(($urandom % 500) == 0, ($urandom % 16) == 0, 1'($urandom % 2),
          ($urandom % 4 != 0) ? 8'h43 : 8'($urandom), d, tv);
    end
    repeat (3) cyc(0, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0 || cmp < 12) begin
      bad++;
      $display("FAIL drain pending=%0d compared=%0d required pending=0 compared>=12", sb.size(), cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
